// File: rtl/time_display_mux.sv
// Purpose : converts a packed 24-hour time into four 7-segment digits and scans them.
// Latency : 21 kh_clk edges from the capture edge to the display-register update; a new capture every 22 edges.
// Backpres: none; the converter free-runs and the scan reads whatever display value was last loaded.
//
// Ports
//   kh_clk    - 1 kHz clock, rising edge
//   reset     - asynchronous active-high reset
//   disp_time - {hr[26:22], min[21:16], sec[15:10], ms[9:0]}, binary
//   view_sel  - 0: HH.MM, 1: SS.mm (seconds, ms hundreds, ms tens)
//   an        - active-low digit enables, an[0] is the rightmost digit
//   seg       - active-low segments {g,f,e,d,c,b,a}
//   dp        - active-low decimal point
//   busy      - high while a conversion is in flight
module time_display_mux #(
    parameter int unsigned DIG_PERIOD = 1
) (
    input  logic        kh_clk,
    input  logic        reset,
    input  logic [26:0] disp_time,
    input  logic        view_sel,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        busy
);

    // ------------------------------------------------------------------
    // Constants and helpers
    // ------------------------------------------------------------------
    localparam logic [7:0] TICK_LAST = 8'(DIG_PERIOD - 1);
    localparam logic [3:0] LAST_STEP = 4'd9;   // 10 shift/add-3 steps per field
    localparam logic [3:0] DASH_CODE = 4'hF;   // non-decimal digit code renders as a dash

    typedef enum logic [1:0] {
        IDLE,
        CONV_A,
        CONV_B,
        UPDATE
    } state_t;

    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? (n + 4'd3) : n;
    endfunction

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b0111111;
        endcase
        return s;
    endfunction

    // ------------------------------------------------------------------
    // Converter state
    // ------------------------------------------------------------------
    state_t      r_state;
    logic [26:0] r_snap_time;
    logic        r_snap_view;
    logic [9:0]  r_bin;       // binary field being shifted out MSB first
    logic [11:0] r_bcd;       // BCD accumulator {hundreds, tens, units}
    logic [3:0]  r_step;
    logic [7:0]  r_bcd_a;     // field A result; hr/sec never exceed two digits
    logic [15:0] r_disp;      // {d3,d2,d1,d0}
    logic        r_disp_vld;

    logic [9:0]  w_cap_field_a;
    logic [9:0]  w_field_b;
    logic [11:0] w_bcd_next;
    logic        w_snap_ok;
    logic [15:0] w_digits;

    // Field A is taken straight from the inputs on the capture edge so the
    // first shift step can start on the very next edge.
    assign w_cap_field_a = view_sel ? {4'd0, disp_time[15:10]}
                                    : {5'd0, disp_time[26:22]};

    assign w_field_b = r_snap_view ? r_snap_time[9:0]
                                   : {4'd0, r_snap_time[21:16]};

    // One double-dabble step: add 3 to any nibble >= 5, then shift left
    // pulling in the next binary bit. The hundreds nibble is never adjusted:
    // before the final shift it holds at most 4 for any input <= 999, and
    // larger inputs are out of range and replaced by dashes anyway.
    assign w_bcd_next = {r_bcd[10:8], add3(r_bcd[7:4]), add3(r_bcd[3:0]), r_bin[9]};

    assign w_snap_ok = (r_snap_time[26:22] < 5'd24)  &&
                       (r_snap_time[21:16] < 6'd60)  &&
                       (r_snap_time[15:10] < 6'd60)  &&
                       (r_snap_time[9:0]   < 10'd1000);

    // View 1 shows ms hundreds and tens, dropping the ms units digit.
    assign w_digits = r_snap_view ? {r_bcd_a, r_bcd[11:4]}
                                  : {r_bcd_a, r_bcd[7:0]};

    always_ff @(posedge kh_clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            busy        <= 1'b0;
            r_snap_time <= '0;
            r_snap_view <= 1'b0;
            r_bin       <= '0;
            r_bcd       <= '0;
            r_step      <= '0;
            r_bcd_a     <= '0;
            r_disp      <= '0;
            r_disp_vld  <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    r_snap_time <= disp_time;
                    r_snap_view <= view_sel;
                    r_bin       <= w_cap_field_a;
                    r_bcd       <= '0;
                    r_step      <= '0;
                    r_state     <= CONV_A;
                    busy        <= 1'b1;
                end

                CONV_A: begin
                    if (r_step == LAST_STEP) begin
                        // Field A complete: park it and preload field B.
                        r_bcd_a <= w_bcd_next[7:0];
                        r_bin   <= w_field_b;
                        r_bcd   <= '0;
                        r_step  <= '0;
                        r_state <= CONV_B;
                    end else begin
                        r_bcd  <= w_bcd_next;
                        r_bin  <= r_bin << 1;
                        r_step <= r_step + 4'd1;
                    end
                end

                CONV_B: begin
                    r_bcd <= w_bcd_next;
                    r_bin <= r_bin << 1;
                    if (r_step == LAST_STEP) begin
                        r_step  <= '0;
                        r_state <= UPDATE;
                    end else begin
                        r_step <= r_step + 4'd1;
                    end
                end

                UPDATE: begin
                    if (w_snap_ok) begin
                        r_disp     <= w_digits;
                        r_disp_vld <= 1'b1;
                    end else begin
                        r_disp     <= {4{DASH_CODE}};
                        r_disp_vld <= 1'b0;
                    end
                    r_state <= IDLE;
                    busy    <= 1'b0;
                end

                default: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Digit scan
    // ------------------------------------------------------------------
    logic [7:0] r_tick;
    logic [1:0] r_idx;

    logic       w_tick_wrap;
    logic [1:0] w_idx_next;
    logic [3:0] w_digit;

    assign w_tick_wrap = (r_tick == TICK_LAST);
    assign w_idx_next  = r_idx + 2'd1;

    always_comb begin
        w_digit = r_disp[3:0];
        case (w_idx_next)
            2'd0: w_digit = r_disp[3:0];
            2'd1: w_digit = r_disp[7:4];
            2'd2: w_digit = r_disp[11:8];
            2'd3: w_digit = r_disp[15:12];
            default: w_digit = r_disp[3:0];
        endcase
    end

    // Outputs load only when the index advances, reading r_disp before any
    // same-edge update, so a fresh display value appears from the next advance.
    always_ff @(posedge kh_clk or posedge reset) begin
        if (reset) begin
            r_tick <= '0;
            r_idx  <= 2'd3;
            an     <= 4'b1111;
            seg    <= 7'b1111111;
            dp     <= 1'b1;
        end else if (w_tick_wrap) begin
            r_tick <= '0;
            r_idx  <= w_idx_next;
            an     <= ~(4'b0001 << w_idx_next);
            seg    <= seg_code(w_digit);
            dp     <= ~((w_idx_next == 2'd2) && r_disp_vld);
        end else begin
            r_tick <= r_tick + 8'd1;
        end
    end

endmodule

// File: tb/tb_time_display_mux.sv
module tb_time_display_mux;

    logic        kh_clk;
    logic        reset;
    logic [26:0] disp_time;
    logic        view_sel;
    logic [3:0]  an,  an3;
    logic [6:0]  seg, seg3;
    logic        dp,  dp3;
    logic        busy, busy3;

    time_display_mux #(.DIG_PERIOD(1)) u_dut (
        .kh_clk(kh_clk), .reset(reset), .disp_time(disp_time), .view_sel(view_sel),
        .an(an), .seg(seg), .dp(dp), .busy(busy)
    );

    time_display_mux #(.DIG_PERIOD(3)) u_dut3 (
        .kh_clk(kh_clk), .reset(reset), .disp_time(disp_time), .view_sel(view_sel),
        .an(an3), .seg(seg3), .dp(dp3), .busy(busy3)
    );

    initial begin
        kh_clk = 1'b0;
        forever #5 kh_clk = ~kh_clk;
    end

    typedef struct packed {
        logic [3:0][6:0] seg;
        logic [3:0]      dp;
    } exp_t;

    typedef struct {
        logic [26:0] t;
        logic        v;
    } stim_t;

    exp_t  q[$];
    stim_t dir_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    int    n_pops  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction

    function automatic logic [26:0] mk_time(input int hr, input int mn, input int sc, input int ms);
        return {5'(hr), 6'(mn), 6'(sc), 10'(ms)};
    endfunction

    function automatic exp_t model(input logic [26:0] t, input logic v);
        exp_t e;
        int   d[4];
        int   hr = int'(t[26:22]);
        int   mn = int'(t[21:16]);
        int   sc = int'(t[15:10]);
        int   ms = int'(t[9:0]);
        bit   ok = (hr < 24) && (mn < 60) && (sc < 60) && (ms < 1000);
        if (!v) begin
            d[3] = hr / 10; d[2] = hr % 10; d[1] = mn / 10;  d[0] = mn % 10;
        end else begin
            d[3] = sc / 10; d[2] = sc % 10; d[1] = ms / 100; d[0] = (ms / 10) % 10;
        end
        for (int i = 0; i < 4; i++) begin
            e.seg[i] = ok ? seg_of(d[i]) : 7'b0111111;
            e.dp[i]  = (ok && i == 2) ? 1'b0 : 1'b1;
        end
        return e;
    endfunction

    function automatic logic [26:0] rand_time();
        int hr = int'($urandom_range(0, 23));
        int mn = int'($urandom_range(0, 59));
        int sc = int'($urandom_range(0, 59));
        int ms = int'($urandom_range(0, 999));
        if ($urandom_range(0, 7) == 0) begin
            case ($urandom_range(0, 3))
                0: hr = int'($urandom_range(24, 31));
                1: mn = int'($urandom_range(60, 63));
                2: sc = int'($urandom_range(60, 63));
                default: ms = int'($urandom_range(1000, 1023));
            endcase
        end
        return mk_time(hr, mn, sc, ms);
    endfunction

    // ---------------- driver: presents a value before each capture edge ----------------
    initial begin
        stim_t s;
        disp_time = '0;
        view_sel  = 1'b0;
        forever begin
            @(negedge kh_clk);
            if (reset === 1'b0 && busy === 1'b0) begin
                if (dir_q.size() > 0) begin
                    s = dir_q.pop_front();
                end else begin
                    s.t = rand_time();
                    s.v = 1'($urandom_range(0, 1));
                end
                disp_time = s.t;
                view_sel  = s.v;
                q.push_back(model(s.t, s.v));
            end else begin
                // Mid-conversion noise must not leak into the result.
                disp_time = 27'($urandom);
                view_sel  = 1'($urandom_range(0, 1));
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    task automatic cmp_scan(input string tag, input exp_t e, input logic [3:0] last_an);
        int idx;
        check($sformatf("%s an_rotate", tag), {28'd0, an}, {28'd0, last_an[2:0], last_an[3]});
        idx = (an == 4'b1110) ? 0 : (an == 4'b1101) ? 1 : (an == 4'b1011) ? 2 : 3;
        check($sformatf("%s seg[%0d]", tag, idx), {25'd0, seg}, {25'd0, e.seg[idx]});
        check($sformatf("%s dp[%0d]", tag, idx), {31'd0, dp}, {31'd0, e.dp[idx]});
    endtask

    initial begin
        exp_t       cur, prev_exp;
        logic       prev_busy;
        logic [3:0] last_an;
        int         scan_left, busy_hi, cyc, have_fall;
        prev_busy = 1'b0; last_an = 4'b1111; scan_left = 0;
        busy_hi = 0; cyc = 0; have_fall = 0;
        prev_exp = model(27'd0, 1'b0);
        cur = prev_exp;
        forever begin
            @(negedge kh_clk);
            if (reset !== 1'b0) begin
                q.delete();
                prev_busy = 1'b0; last_an = 4'b1111; scan_left = 0;
                busy_hi = 0; cyc = 0; have_fall = 0;
                prev_exp = model(27'd0, 1'b0);
            end else begin
                cyc++;
                if (busy === 1'b1) busy_hi++;
                if (prev_busy === 1'b1 && busy === 1'b0) begin
                    // Update landed on this edge, but the scan still shows the old value.
                    cmp_scan("coincide", prev_exp, last_an);
                    if (have_fall != 0) begin
                        check("period", cyc, 22);
                        check("busy_high", busy_hi, 21);
                    end
                    have_fall = 1; cyc = 0; busy_hi = 0;
                    if (q.size() == 0) begin
                        check("expect_available", 0, 1);
                    end else begin
                        cur = q.pop_front();
                        n_pops++;
                        prev_exp  = cur;
                        scan_left = 4;
                    end
                end else if (scan_left > 0) begin
                    cmp_scan("scan", cur, last_an);
                    scan_left--;
                end
                prev_busy = busy;
                last_an   = an;
            end
        end
    end

    // ---------------- DIG_PERIOD=3 scan-hold checker ----------------
    initial begin
        logic [3:0] last3;
        int         run, seen, left;
        last3 = 4'b1111; run = 0; seen = 0; left = 20;
        forever begin
            @(negedge kh_clk);
            if (reset !== 1'b0) begin
                last3 = 4'b1111; run = 0; seen = 0;
            end else if (an3 === last3) begin
                run++;
            end else begin
                if (seen >= 1 && left > 0) begin
                    check("p3 hold", run, 3);
                    check("p3 rotate", {28'd0, an3}, {28'd0, last3[2:0], last3[3]});
                    left--;
                end
                seen++;
                last3 = an3;
                run   = 1;
            end
        end
    end

    // ---------------- directed sequences ----------------
    task automatic post_release_checks(input string tag);
        logic [3:0] exp_an;
        @(posedge kh_clk); #1;
        check($sformatf("%s first an", tag), {28'd0, an}, 32'b1110);
        check($sformatf("%s first seg", tag), {25'd0, seg}, 32'b1000000);
        check($sformatf("%s first dp", tag), {31'd0, dp}, 32'd1);
        check($sformatf("%s busy after capture", tag), {31'd0, busy}, 32'd1);
        check($sformatf("%s p3 an held", tag), {28'd0, an3}, 32'b1111);
        exp_an = 4'b1110;
        for (int k = 1; k < 4; k++) begin
            @(posedge kh_clk); #1;
            exp_an = {exp_an[2:0], exp_an[3]};
            check($sformatf("%s zero an%0d", tag, k), {28'd0, an}, {28'd0, exp_an});
            check($sformatf("%s zero seg%0d", tag, k), {25'd0, seg}, 32'b1000000);
            check($sformatf("%s zero dp%0d", tag, k), {31'd0, dp}, (k == 2) ? 32'd0 : 32'd1);
            if (k == 2) begin
                check($sformatf("%s p3 first an", tag), {28'd0, an3}, 32'b1110);
                check($sformatf("%s p3 first seg", tag), {25'd0, seg3}, 32'b1000000);
                check($sformatf("%s p3 first dp", tag), {31'd0, dp3}, 32'd1);
            end
        end
    endtask

    task automatic check_reset_state(input string tag);
        check($sformatf("%s an", tag), {28'd0, an}, 32'b1111);
        check($sformatf("%s seg", tag), {25'd0, seg}, 32'b1111111);
        check($sformatf("%s dp", tag), {31'd0, dp}, 32'd1);
        check($sformatf("%s busy", tag), {31'd0, busy}, 32'd0);
        check($sformatf("%s p3 an", tag), {28'd0, an3}, 32'b1111);
        check($sformatf("%s p3 busy", tag), {31'd0, busy3}, 32'd0);
    endtask

    task automatic wait_pops(input int target, input int limit);
        int c = 0;
        while (n_pops < target && c < limit) begin
            @(negedge kh_clk);
            c++;
        end
        check("conversions_seen", (n_pops >= target) ? 32'd1 : 32'd0, 32'd1);
    endtask

    initial begin
        int c;
        int target;
        dir_q.push_back('{t: mk_time(13, 45, 0, 0),   v: 1'b0});
        dir_q.push_back('{t: mk_time(12, 30, 59, 987), v: 1'b1});
        dir_q.push_back('{t: mk_time(24, 10, 20, 300), v: 1'b0});
        dir_q.push_back('{t: mk_time(10, 20, 30, 1000), v: 1'b1});
        dir_q.push_back('{t: mk_time(23, 59, 59, 999), v: 1'b0});
        dir_q.push_back('{t: mk_time(0, 0, 0, 9),      v: 1'b1});

        reset = 1'b0;
        #1 reset = 1'b1;
        #2 check_reset_state("reset");
        @(posedge kh_clk); #2 reset = 1'b0;
        post_release_checks("init");

        wait_pops(24, 2000);

        // Reset 10 edges into a conversion.
        c = 0;
        @(negedge kh_clk);
        while (busy !== 1'b0 && c < 100) begin
            @(negedge kh_clk);
            c++;
        end
        @(posedge kh_clk);
        repeat (10) @(posedge kh_clk);
        #2 reset = 1'b1;
        #1 check_reset_state("midreset");
        repeat (2) @(posedge kh_clk);
        #2 reset = 1'b0;
        post_release_checks("rerun");

        target = n_pops + 8;
        wait_pops(target, 600);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/time_display_mux.md
TIME_DISPLAY_MUX -- requirements
Module: time_display_mux

Interface
REQ-001 Parameter: DIG_PERIOD, default 1, kh_clk cycles each digit is enabled (legal range 1..255).
REQ-002 Port: kh_clk  in  1  sole clock, 1 kHz, rising-edge.
REQ-003 Port: reset  in  1  asynchronous, active-high reset.
REQ-004 Port: disp_time  in  27  packed time {hr[26:22], min[21:16], sec[15:10], ms[9:0]}, binary, driven by the 24-hour clock stage.
REQ-005 Port: view_sel  in  1  0 = HH.MM view, 1 = SS.mm view (seconds, ms hundreds, ms tens).
REQ-006 Port: an  out  4  digit enables, active-low, an[0] = rightmost digit.
REQ-007 Port: seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-008 Port: dp  out  1  decimal point, active-low.
REQ-009 Port: busy  out  1  high while a conversion is in progress.

Function
REQ-010 The converter FSM SHALL have the states IDLE, CONV_A, CONV_B and UPDATE.
REQ-011 IDLE: on each kh_clk edge, the FSM SHALL capture disp_time and view_sel into snapshot registers and go to CONV_A.
REQ-012 CONV_A SHALL run exactly 10 sequential double-dabble shift/add-3 cycles on field A, zero-extended to 10 bits, producing 3 BCD digits; the FSM then SHALL go to CONV_B.
REQ-013 CONV_B SHALL do the same on field B in 10 cycles, then go to UPDATE.
REQ-014 Field A SHALL be hr (view 0) or sec (view 1); field B SHALL be min (view 0) or ms (view 1).
REQ-015 UPDATE SHALL load the 4-digit display register in one cycle, then the FSM SHALL return to IDLE.
REQ-016 Latency SHALL be 21 edges from the capture edge to the display-register update; the next capture SHALL occur on edge 22.
REQ-017 The display register SHALL be {d3,d2,d1,d0}.
REQ-018 View 0 digit mapping SHALL be d3 = hr tens, d2 = hr units, d1 = min tens, d0 = min units.
REQ-019 View 1 digit mapping SHALL be d3 = sec tens, d2 = sec units, d1 = ms hundreds, d0 = ms tens.
REQ-020 If the snapshot has hr>23, min>59, sec>59 or ms>999, UPDATE SHALL mark every digit as a dash and hold dp off, regardless of view.
REQ-021 Changes on view_sel or disp_time outside the capture edge SHALL have no effect on the conversion in progress.
REQ-022 busy SHALL be 1 in CONV_A, CONV_B and UPDATE, and 0 in IDLE.
REQ-023 Scan counting:
  - A tick counter SHALL count 0..DIG_PERIOD-1 on every edge.
  - On the edge where it wraps, the digit index SHALL advance by 1 modulo 4 (3 wraps to 0).
REQ-024 an, seg and dp SHALL be registers, loaded only on an index-advance edge, from the new index and the current display register.
REQ-025 an SHALL have exactly one bit low, at bit position = index.
REQ-026 dp SHALL be 0 when index = 2 and the display is valid, and 1 otherwise.
REQ-027 Segment codes, seg {g..a}, SHALL be:
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001
  - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000
  - dash = 0111111
REQ-028 A display-register update coinciding with an index-advance edge SHALL take effect on the next advance; the old value SHALL be shown on the coinciding edge.

Reset
REQ-029 While reset is high, asynchronously, the block SHALL force:
  - an = 1111, seg = 1111111, dp = 1, busy = 0
  - FSM = IDLE, tick = 0, index = 3
  - display register = 0000 (valid), snapshot = 0
REQ-030 Reset asserted mid-conversion SHALL discard the partial conversion; the first edge after release SHALL perform a fresh capture.
REQ-031 With DIG_PERIOD=1, the first edge after release SHALL give index 0, an = 1110, seg = 1000000 ("0"), dp = 1.

Verification
REQ-032 Time view: reset, then disp_time = {13,45,0,0}, view_sel = 0, run 30 cycles -> display register 1,3,4,5; an cycles 1110, 1101, 1011, 0111; seg is 0010010 at an = 1110 and 0110000 with dp = 0 at an = 1011.
REQ-033 Seconds view: sec = 59, ms = 987, view_sel = 1 -> digits d3..d0 = 5,9,9,8; busy high for exactly 21 of every 22 cycles.
REQ-034 Invalid input: hr = 24 -> after update, all four digits show seg = 0111111 and dp = 1 on every digit.
REQ-035 Reset mid-conversion: assert reset at cycle 10 after capture -> an = 1111 and busy = 0 immediately; after release the display shows 0000 until the fresh conversion lands 21 edges later.
REQ-036 View held during conversion: toggle view_sel 5 cycles after capture -> the current update uses the old view; the next capture uses the new one.
REQ-037 Scan period: DIG_PERIOD = 3 -> each an value is held exactly 3 cycles; the full scan takes 12 cycles.
